// File: rtl/iap_kpa_top.sv
// FTDI 245-style receive path into a word FIFO, drained over an SPI mode-0 slave.
// SPI logic works on synchronized SCK/MOSI/nCS; the FTDI bus shares clk100_in and is sampled directly.
module iap_kpa_top #(
  parameter int FIFO_DEPTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk100_in,
  input  logic        nrst_in,
  output logic [7:0]  LED,
  input  logic        RXF_N,
  input  logic        TXE_N,
  output logic        OE_N,
  output logic        RD_N,
  output logic        WR_N,
  inout  wire  [3:0]  BE,
  inout  wire  [31:0] DATA,
  input  logic        SCK,
  input  logic        MOSI,
  output logic        MISO,
  input  logic        nCS
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [7:0] CMD_STATUS = 8'h5A;
  localparam logic [7:0] CMD_READ   = 8'h0B;

  typedef enum logic [1:0] {S_IDLE, S_TURN, S_READ} state_t;

  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d, mosi_sync_q, mosi_sync_d;
  logic [SYNC_STAGES-1:0] ncs_sync_q, ncs_sync_d, rxf_sync_q, rxf_sync_d;
  logic          sck_prev_q, sck_prev_d, armed_q, armed_d, cmd_done_q, cmd_done_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [6:0]    rx_sh_q, rx_sh_d;
  logic [7:0]    tx_q, tx_d, cmd_q, cmd_d, led_q, led_d;
  logic [3:0]    used_q, used_d;
  state_t        state_q, state_d;
  logic [35:0]   mem_q [FIFO_DEPTH];
  logic [35:0]   mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic        sck_s, mosi_s, ncs_s, rxf_s, active, sck_rise, byte_done, read_load;
  logic        fifo_empty, fifo_full, push, pop, last_byte, oe_n, rd_n;
  logic [7:0]  rx_byte, cur_cmd, status_byte, rd_byte, next_tx;
  logic [35:0] head;
  logic [3:0]  rem, pick_oh;
  logic        unused_txe;

  assign unused_txe = TXE_N;

  // SPI slave: receive shifter, command capture and next-MISO-byte fetch
  always_comb begin
    sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], SCK};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
    ncs_sync_d  = {ncs_sync_q[SYNC_STAGES-2:0], nCS};
    rxf_sync_d  = {rxf_sync_q[SYNC_STAGES-2:0], RXF_N};
    sck_s  = sck_sync_q[SYNC_STAGES-1];
    mosi_s = mosi_sync_q[SYNC_STAGES-1];
    ncs_s  = ncs_sync_q[SYNC_STAGES-1];
    rxf_s  = rxf_sync_q[SYNC_STAGES-1];

    active      = armed_q && !ncs_s;
    sck_rise    = active && sck_s && !sck_prev_q;
    byte_done   = sck_rise && (bit_cnt_q == 3'd7);
    rx_byte     = {rx_sh_q, mosi_s};
    cur_cmd     = cmd_done_q ? cmd_q : rx_byte;
    fifo_empty  = (count_q == '0);
    fifo_full   = (count_q == CW'(FIFO_DEPTH));
    status_byte = {fifo_empty, fifo_full, rxf_s, 5'(count_q)};

    // Head word bytes go out LSB first, skipping disabled lanes
    head      = mem_q[rd_ptr_q];
    rem       = head[35:32] & ~used_q;
    pick_oh   = rem & (~rem + 4'd1);
    last_byte = ((rem & ~pick_oh) == 4'd0);
    case (pick_oh)
      4'b0001: rd_byte = head[7:0];
      4'b0010: rd_byte = head[15:8];
      4'b0100: rd_byte = head[23:16];
      4'b1000: rd_byte = head[31:24];
      default: rd_byte = 8'h00;
    endcase

    read_load = byte_done && (cur_cmd == CMD_READ) && !fifo_empty;
    pop       = read_load && last_byte;
    next_tx   = 8'h00;
    if (byte_done && cur_cmd == CMD_STATUS) next_tx = status_byte;
    if (read_load)                          next_tx = rd_byte;

    used_d = used_q;
    if (pop)            used_d = 4'd0;
    else if (read_load) used_d = used_q | pick_oh;

    sck_prev_d = sck_s;
    armed_d    = armed_q | ncs_s;
    bit_cnt_d  = bit_cnt_q;
    rx_sh_d    = rx_sh_q;
    tx_d       = tx_q;
    cmd_d      = cmd_q;
    cmd_done_d = cmd_done_q;
    led_d      = led_q;
    if (ncs_s) begin
      bit_cnt_d  = 3'd0;
      cmd_done_d = 1'b0;
      tx_d       = 8'h00;
    end else if (sck_rise) begin
      bit_cnt_d = bit_cnt_q + 3'd1;
      rx_sh_d   = rx_byte[6:0];
      tx_d      = {tx_q[6:0], 1'b0};
      if (byte_done) begin
        tx_d = next_tx;
        if (!cmd_done_q) begin
          cmd_d      = rx_byte;
          cmd_done_d = 1'b1;
          led_d      = rx_byte;
        end
      end
    end
  end

  // FTDI read FSM and FIFO bookkeeping
  always_comb begin
    state_d = state_q;
    oe_n    = 1'b1;
    rd_n    = 1'b1;
    push    = 1'b0;
    case (state_q)
      S_TURN: oe_n = 1'b0;
      S_READ: begin
        oe_n = 1'b0;
        rd_n = 1'b0;
        push = !RXF_N && (BE != 4'd0) && !fifo_full;
      end
      default: ;
    endcase

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: ;
    endcase

    case (state_q)
      S_IDLE: if (!RXF_N && !fifo_full) state_d = S_TURN;
      S_TURN: state_d = S_READ;
      S_READ: if (RXF_N || count_d == CW'(FIFO_DEPTH)) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = {BE, DATA};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk100_in) begin
    if (!nrst_in) begin
      sck_sync_q  <= '0;
      mosi_sync_q <= '0;
      // nCS sync resets low so a frame held open across reset cannot re-arm the slave
      ncs_sync_q  <= '0;
      rxf_sync_q  <= '1;
      sck_prev_q  <= 1'b0;
      armed_q     <= 1'b0;
      bit_cnt_q   <= 3'd0;
      rx_sh_q     <= 7'd0;
      tx_q        <= 8'h00;
      cmd_q       <= 8'h00;
      cmd_done_q  <= 1'b0;
      led_q       <= 8'h00;
      used_q      <= 4'd0;
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      sck_sync_q  <= sck_sync_d;
      mosi_sync_q <= mosi_sync_d;
      ncs_sync_q  <= ncs_sync_d;
      rxf_sync_q  <= rxf_sync_d;
      sck_prev_q  <= sck_prev_d;
      armed_q     <= armed_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_sh_q     <= rx_sh_d;
      tx_q        <= tx_d;
      cmd_q       <= cmd_d;
      cmd_done_q  <= cmd_done_d;
      led_q       <= led_d;
      used_q      <= used_d;
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      mem_q       <= mem_d;
    end
  end

  assign LED  = led_q;
  assign OE_N = oe_n;
  assign RD_N = rd_n;
  assign WR_N = 1'b1;
  assign MISO = active ? tx_q[7] : 1'bz;

endmodule

// File: tb/tb_iap_kpa_top.sv
// Directed bench for iap_kpa_top: FTDI bus driver, SPI mode-0 master, MISO byte scoreboard.
module tb_iap_kpa_top;
  logic clk = 1'b0, nrst = 1'b0;
  logic rxf_n = 1'b1, txe_n = 1'b1, sck = 1'b0, mosi = 1'b0, ncs = 1'b1;
  logic [31:0] ft_data = '0;
  logic [3:0]  ft_be = '0;
  wire  [31:0] DATA;
  wire  [3:0]  BE;
  wire  [7:0]  led;
  wire         oe_n, rd_n, wr_n, miso;
  int          total = 0, bad = 0;
  logic [7:0]  exp_q[$];
  logic [31:0] mq[$];

  assign DATA = ft_data;
  assign BE   = ft_be;

  always #5 clk = ~clk;

  iap_kpa_top #(.FIFO_DEPTH(16), .SYNC_STAGES(2)) dut (
    .clk100_in(clk), .nrst_in(nrst), .LED(led), .RXF_N(rxf_n), .TXE_N(txe_n),
    .OE_N(oe_n), .RD_N(rd_n), .WR_N(wr_n), .BE(BE), .DATA(DATA),
    .SCK(sck), .MOSI(mosi), .MISO(miso), .nCS(ncs)
  );

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] fw(input int i);
    logic [7:0] k;
    k = 8'(i);
    return {8'hD0 + k, 8'hC0 + k, 8'hB0 + k, 8'hA0 + k};
  endfunction

  // Mode 0: MOSI set while SCK low, MISO sampled on the rising edge
  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - n; i--) begin
      mosi = tx[i];
      #40;
      sck = 1'b1;
      rx[i] = miso;
      #40;
      sck = 1'b0;
    end
  endtask

  task automatic cmp_pop(input string tag, input logic [7:0] rx);
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s observed=%02h expected=<scoreboard empty>", tag, rx);
    end else begin
      check8(tag, rx, exp_q.pop_front());
    end
  endtask

  task automatic frame(input logic [7:0] cmd, input int npay);
    logic [7:0] rx;
    ncs = 1'b0;
    #80;
    spi_bits(cmd, 8, rx);
    cmp_pop($sformatf("miso_cmd_%02h", cmd), rx);
    for (int p = 0; p < npay; p++) begin
      spi_bits(8'h00, 8, rx);
      cmp_pop($sformatf("miso_%02h_pay%0d", cmd, p), rx);
    end
    #40;
    ncs = 1'b1;
    #100;
  endtask

  task automatic load_word(input logic [31:0] d, input logic [3:0] b);
    @(negedge clk);
    ft_data = d;
    ft_be   = b;
    rxf_n   = 1'b0;
    @(posedge clk); #1;
    check8("turn_oe_n", {7'd0, oe_n}, 8'h00);
    check8("turn_rd_n", {7'd0, rd_n}, 8'h01);
    @(posedge clk); #1;
    check8("read_rd_n", {7'd0, rd_n}, 8'h00);
    @(posedge clk); #1;
    rxf_n = 1'b1;
    @(posedge clk); #1;
    check8("idle_oe_n", {7'd0, oe_n}, 8'h01);
    check8("idle_rd_n", {7'd0, rd_n}, 8'h01);
  endtask

  initial begin
    logic [7:0] rx;
    int reads, wi;
    logic took;

    repeat (100) @(posedge clk);
    #1;
    check8("rst_oe_n", {7'd0, oe_n}, 8'h01);
    check8("rst_rd_n", {7'd0, rd_n}, 8'h01);
    check8("rst_wr_n", {7'd0, wr_n}, 8'h01);
    check8("rst_led",  led, 8'h00);
    nrst = 1'b1;
    repeat (10) @(posedge clk);

    exp_q.push_back(8'h00); exp_q.push_back(8'hA0);
    frame(8'h5A, 1);
    check8("led_status", led, 8'h5A);

    for (int r = 0; r < 2; r++) begin
      exp_q.push_back(8'h00); exp_q.push_back(8'h00);
      frame(8'h0B, 1);
      check8("led_read_empty", led, 8'h0B);
    end

    load_word(32'h0000_0101, 4'hF);
    exp_q.push_back(8'h00); exp_q.push_back(8'h21);
    frame(8'h5A, 1);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h01); exp_q.push_back(8'h01);
    exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    frame(8'h0B, 4);
    exp_q.push_back(8'h00); exp_q.push_back(8'hA0);
    frame(8'h5A, 1);

    // BE=0 word is dropped; sparse BE skips lanes
    load_word(32'hFFFF_FFFF, 4'h0);
    exp_q.push_back(8'h00); exp_q.push_back(8'hA0);
    frame(8'h5A, 1);
    load_word(32'h4433_2211, 4'b0101);
    exp_q.push_back(8'h00); exp_q.push_back(8'h11);
    exp_q.push_back(8'h33); exp_q.push_back(8'h00);
    frame(8'h0B, 3);

    // Fill: the FTDI model advances to the next word after each accepted read cycle
    ft_be = 4'hF;
    wi = 0;
    reads = 0;
    ft_data = fw(0);
    @(negedge clk);
    rxf_n = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      took = !rd_n;
      @(posedge clk); #1;
      if (took) begin
        mq.push_back(ft_data);
        reads++;
        wi++;
        ft_data = fw(wi);
      end
    end
    check8("fill_reads", 8'(reads), 8'd16);
    check8("full_oe_n", {7'd0, oe_n}, 8'h01);
    check8("full_rd_n", {7'd0, rd_n}, 8'h01);
    exp_q.push_back(8'h00); exp_q.push_back(8'h50); exp_q.push_back(8'h50);
    frame(8'h5A, 2);
    rxf_n = 1'b1;
    exp_q.push_back(8'h00); exp_q.push_back(8'h70);
    frame(8'h5A, 1);

    exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    frame(8'h33, 2);
    check8("led_other", led, 8'h33);

    ncs = 1'b0;
    #80;
    spi_bits(8'h5A, 4, rx);
    #40;
    ncs = 1'b1;
    #100;
    check8("led_partial", led, 8'h33);

    exp_q.push_back(8'h00);
    for (int w = 0; w < 2; w++)
      for (int b = 0; b < 4; b++) exp_q.push_back(mq[w][8*b +: 8]);
    frame(8'h0B, 8);
    check8("led_after_partial", led, 8'h0B);
    exp_q.push_back(8'h00); exp_q.push_back(8'h2E);
    frame(8'h5A, 1);

    // Reset mid-frame, then clock bits with nCS still low: they must be ignored
    ncs = 1'b0;
    #80;
    spi_bits(8'h0B, 5, rx);
    @(posedge clk); #1;
    nrst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check8("midrst_led",  led, 8'h00);
    check8("midrst_oe_n", {7'd0, oe_n}, 8'h01);
    nrst = 1'b1;
    spi_bits(8'h5A, 8, rx);
    #40;
    ncs = 1'b1;
    #100;
    check8("postrst_led", led, 8'h00);
    exp_q.push_back(8'h00); exp_q.push_back(8'hA0);
    frame(8'h5A, 1);
    check8("postrst_led_status", led, 8'h5A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
